fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences reads of the combinational instruction memory.
- Drives the memory read address and registers the returned word into a fetch register.
- Presents the word to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects with flush, and an orderly drain-to-halt.

Parameters:
- ADDR_BITS, 5, byte-address bits implemented by the instruction memory; PC wraps modulo 2^ADDR_BITS.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; only bits [ADDR_BITS-1:2] are significant.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- imemAddress  output  32  read address to instruction memory: {zeros, pc[ADDR_BITS-1:0]}, combinational from the PC register.
- imemInstruction  input  32  instruction word returned combinationally for imemAddress.
- instrOut  output  32  registered instruction presented to decode.
- instrPC  output  32  byte address instrOut was fetched from.
- instrValid  output  1  instrOut/instrPC hold a live instruction.
- instrReady  input  1  decode accepts instrOut this cycle.
- branchTaken  input  1  single-cycle redirect request (taken branch or jump).
- branchTarget  input  32  redirect byte address.
- haltReq  input  1  request to stop fetching.
- halted  output  1  block is in HALT.
- misalignErr  output  1  sticky: a redirect target had bits [1:0] nonzero.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=BOOT; pc=RESET_PC masked to ADDR_BITS with [1:0] cleared; instrOut=0; instrPC=0; instrValid=0; halted=0; misalignErr=0.
- PC arithmetic:
  - pc is ADDR_BITS wide internally, zero-extended on outputs.
  - Next sequential pc = (pc + PC_STEP) mod 2^ADDR_BITS; 5'd28 + 4 wraps to 5'd0.
- Redirect masking: redirect pc = branchTarget[ADDR_BITS-1:0] with [1:0] forced to 0. Upper target bits are ignored without error.
- Accept condition: accept = instrValid & instrReady. Capture condition: load = ~instrValid | instrReady.
- BOOT (1 cycle): no fetch, instrValid stays 0. Next state is RUN, or DRAIN if haltReq=1.
- RUN, evaluated in priority order:
  1. branchTaken=1: pc<=redirect pc; instrValid<=0 (flush, even if decode is not ready); instrOut/instrPC hold. Fetch from the target occurs next cycle. This gives a redirect-to-valid latency of 2 cycles.
  2. load=1: instrOut<=imemInstruction; instrPC<=pc; instrValid<=1; pc<=next sequential pc.
  3. Otherwise (stall: instrValid & ~instrReady): pc, instrOut, instrPC and instrValid all hold.
  4. If haltReq=1 in the same cycle, the above action still applies, then state<=DRAIN.
- Throughput: with instrReady held at 1, one instruction per cycle.
- DRAIN:
  - No new fetches; pc holds.
  - branchTaken=1: instrValid<=0 and pc<=redirect pc.
  - Otherwise, on accept: instrValid<=0.
  - When instrValid is 0 at the start of a cycle, state<=HALT.
- HALT:
  - halted=1; instrValid=0; pc frozen.
  - All inputs are ignored except reset. HALT is exited only by reset.
- misalignErr: set on any cycle in RUN or DRAIN where branchTaken=1 and branchTarget[1:0]!=0. Cleared only by reset.
- Simultaneous branchTaken and instrReady: the redirect wins. The held instruction counts as accepted by decode, and no new instruction is captured that cycle.
- Reset mid-operation: a reset while stalled, in DRAIN, or in HALT returns to BOOT with the reset values. Any in-flight instruction is discarded.
- instrOut/instrPC hold their last values whenever instrValid=0. The bench must not check them in that case.

Test Plan:
- Sequential fetch: reset, instrReady=1, memory word at byte n = 32'hA000_0000+n → instrPC sequence 0,4,8,…,28,0 (wrap). First instrValid=1 two cycles after reset deasserts. instrOut matches each address.
- Stall: deassert instrReady for 3 cycles while instrPC=8 → instrOut/instrPC/imemAddress hold (instrPC=8, imemAddress=12). On reassert, next instrPC=12.
- Redirect: branchTaken=1, branchTarget=32'h18 while instrPC=4 and instrReady=0 → next cycle instrValid=0, imemAddress=24. Following cycle instrPC=24, instrValid=1, then 28, 0.
- Misaligned, oversized target: branchTarget=32'hFFFF_FF0E → pc=5'd12, misalignErr=1 and stays 1 until reset.
- Halt drain: haltReq=1 with instrValid=1, instrReady=0 for 2 cycles, then instrReady=1 → exactly one more accept, then instrValid=0, halted=1. Later branchTaken pulses are ignored.
- Reset mid-stall: assert reset while instrValid=1, instrReady=0, instrPC=16 → next cycle instrValid=0, imemAddress=RESET_PC, halted=0, misalignErr=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller: owns the PC, reads a
//               combinational instruction memory and hands words to decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int          ADDR_BITS = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imemAddress,
    input  logic [31:0] imemInstruction,
    output logic [31:0] instrOut,
    output logic [31:0] instrPC,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        haltReq,
    output logic        halted,
    output logic        misalignErr
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0] c_RESET_PC = {RESET_PC[ADDR_BITS-1:2], 2'b00};
    localparam logic [ADDR_BITS-1:0] c_STEP     = ADDR_BITS'(PC_STEP);

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_pc;
    logic [ADDR_BITS-1:0] r_instr_pc;
    logic [31:0]          r_instr;
    logic                 r_valid;
    logic                 r_halted;
    logic                 r_misalign;

    logic [ADDR_BITS-1:0] w_pc_next;
    logic [ADDR_BITS-1:0] w_redirect;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_unused;

    assign w_pc_next  = r_pc + c_STEP;
    assign w_redirect = {branchTarget[ADDR_BITS-1:2], 2'b00};
    assign w_load     = ~r_valid | instrReady;
    assign w_accept   = r_valid & instrReady;
    // Upper target bits are silently dropped; only the low two flag an error.
    assign w_misalign = branchTaken & (|branchTarget[1:0]);
    assign w_unused   = &{1'b0, branchTarget[31:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= c_RESET_PC;
            r_instr_pc <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= haltReq ? DRAIN : RUN;
                end
                RUN: begin
                    if (branchTaken) begin
                        r_pc    <= w_redirect;
                        r_valid <= 1'b0;
                    end else if (w_load) begin
                        r_instr    <= imemInstruction;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= w_pc_next;
                    end
                    if (haltReq) begin
                        r_state <= DRAIN;
                    end
                    if (w_misalign) begin
                        r_misalign <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (branchTaken) begin
                        r_pc    <= w_redirect;
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                    end
                    // Halt only once the output register was already empty.
                    if (!r_valid) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                    if (w_misalign) begin
                        r_misalign <= 1'b1;
                    end
                end
                HALT: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign imemAddress = {{(32-ADDR_BITS){1'b0}}, r_pc};
    assign instrOut    = r_instr;
    assign instrPC     = {{(32-ADDR_BITS){1'b0}}, r_instr_pc};
    assign instrValid  = r_valid;
    assign halted      = r_halted;
    assign misalignErr = r_misalign;

endmodule

`default_nettype wire
